if_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS CPU. It holds the PC, runs a req/ack handshake with instruction memory, and owns the IF/ID pipeline register. It consumes the hazard unit's fetch/decode stalls and the decode-stage branch redirect. It produces the decode-stage instruction, its PC+4, and a fetch-busy stall that the top level ORs into the decode/execute controls.

---
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the pipelined MIPS CPU.
//
// Holds the PC, runs a req/ack handshake with instruction memory and owns
// the IF/ID pipeline register. An instruction that arrives while the
// pipeline is held is parked in a one-word buffer so memory is released
// immediately; it is handed to decode once the hold clears.
//
// Configuration macro: IF_DELAY_SLOT_EN
//   defined   - the instruction fetched alongside a taken branch enters
//               decode as a valid delay-slot instruction.
//   undefined - that instruction is squashed (InstrD=0, ValidD=0).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   StallF, StallD  hazard-unit stalls (either one holds the whole fetch)
//   PCSrcD          taken branch resolved in decode
//   PCBranchD       branch target
//   imem_req        fetch request to instruction memory
//   imem_addr       fetch address (PCF)
//   imem_ack        memory returns imem_rdata this cycle
//   imem_rdata      fetched instruction
//   InstrD          IF/ID instruction
//   PCPlus4D        IF/ID PC+4
//   ValidD          IF/ID holds a real instruction (0 = bubble)
//   FetchStall      fetch cannot deliver an instruction this cycle

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchStall
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pcf;
  logic [31:0] buffer;
  logic [31:0] pc_plus4;
  logic [31:0] fetched;
  logic        hold;
  logic        xfer_mem;
  logic        xfer_buf;
  logic        xfer;

  assign hold     = StallF | StallD;
  assign pc_plus4 = pcf + 32'd4;

  // A transfer moves one instruction into IF/ID, either straight from
  // memory or from the buffer filled during an earlier hold.
  assign xfer_mem = (state == FETCH) & imem_ack & ~hold;
  assign xfer_buf = (state == HOLD) & ~hold;
  assign xfer     = xfer_mem | xfer_buf;
  assign fetched  = xfer_buf ? buffer : imem_rdata;

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pcf;
  assign FetchStall = (state == START) | ((state == FETCH) & ~imem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= START;
      pcf      <= RESET_PC;
      buffer   <= '0;
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      case (state)
        START: state <= FETCH;
        FETCH: begin
          if (imem_ack & hold) begin
            buffer <= imem_rdata;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (!hold) state <= FETCH;
        end
        default: state <= START;
      endcase

      if (xfer) begin
        PCPlus4D <= pc_plus4;
        pcf      <= PCSrcD ? PCBranchD : pc_plus4;
`ifdef IF_DELAY_SLOT_EN
        InstrD   <= fetched;
        ValidD   <= 1'b1;
`else
        InstrD   <= PCSrcD ? '0 : fetched;
        ValidD   <= ~PCSrcD;
`endif
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, table-driven bench for if_stage.
// Memory model: imem_rdata is a fixed function of imem_addr; imem_ack is
// driven directly by the stimulus (not gated by imem_req, so acks during
// START/HOLD exercise the "ignored" path).

module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        StallD;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FetchStall;

  int unsigned checks;
  int unsigned errors;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchStall (FetchStall)
  );

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = w(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sf;
    logic        sd;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        fs;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic sf, input logic sd, input logic br,
                              input logic [31:0] tgt, input logic ack,
                              input logic req, input logic [31:0] addr,
                              input logic fs, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
    vec_t v;
    v.sf = sf; v.sd = sd; v.br = br; v.tgt = tgt; v.ack = ack;
    v.req = req; v.addr = addr; v.fs = fs; v.instr = instr;
    v.pc4 = pc4; v.valid = valid;
    return v;
  endfunction

  // Instruction expected in D after a taken-branch transfer of word at a.
  function automatic logic [31:0] slot(input logic [31:0] a);
    return DS ? w(a) : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req,
                         input logic [31:0] addr, input logic fs,
                         input logic [31:0] instr, input logic [31:0] pc4,
                         input logic valid);
    chk({tag, " imem_req"},   {31'b0, imem_req},   {31'b0, req});
    chk({tag, " imem_addr"},  imem_addr,           addr);
    chk({tag, " FetchStall"}, {31'b0, FetchStall}, {31'b0, fs});
    chk({tag, " InstrD"},     InstrD,              instr);
    chk({tag, " PCPlus4D"},   PCPlus4D,            pc4);
    chk({tag, " ValidD"},     {31'b0, ValidD},     {31'b0, valid});
  endtask

  task automatic drive(input logic sf, input logic sd, input logic br,
                       input logic [31:0] tgt, input logic ack);
    StallF = sf; StallD = sd; PCSrcD = br; PCBranchD = tgt; imem_ack = ack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;

    //     sf sd br tgt           ack  req addr          fs instr            pc4           v
    tbl[0]  = mk(0,0,0,32'h0,       1,  0, 32'h0,        1, 32'h0,           32'h0,        0);
    tbl[1]  = mk(0,0,0,32'h0,       1,  1, 32'h0,        0, 32'h0,           32'h0,        0);
    tbl[2]  = mk(0,0,0,32'h0,       1,  1, 32'h4,        0, w(32'h0),        32'h4,        1);
    tbl[3]  = mk(0,0,1,32'h100,     1,  1, 32'h8,        0, w(32'h4),        32'h8,        1);
    tbl[4]  = mk(0,0,0,32'h0,       1,  1, 32'h100,      0, slot(32'h8),     32'hC,        DS);
    tbl[5]  = mk(0,0,1,32'h10,      1,  1, 32'h104,      0, w(32'h100),      32'h104,      1);
    tbl[6]  = mk(0,0,1,32'h300,     0,  1, 32'h10,       1, slot(32'h104),   32'h108,      DS);
    tbl[7]  = mk(0,0,0,32'h0,       0,  1, 32'h10,       1, slot(32'h104),   32'h108,      DS);
    tbl[8]  = mk(0,0,0,32'h0,       0,  1, 32'h10,       1, slot(32'h104),   32'h108,      DS);
    tbl[9]  = mk(0,0,0,32'h0,       1,  1, 32'h10,       0, slot(32'h104),   32'h108,      DS);
    tbl[10] = mk(0,0,0,32'h0,       1,  1, 32'h14,       0, w(32'h10),       32'h14,       1);
    tbl[11] = mk(0,0,0,32'h0,       1,  1, 32'h18,       0, w(32'h14),       32'h18,       1);
    tbl[12] = mk(0,0,0,32'h0,       1,  1, 32'h1C,       0, w(32'h18),       32'h1C,       1);
    tbl[13] = mk(1,1,0,32'h0,       1,  1, 32'h20,       0, w(32'h1C),       32'h20,       1);
    tbl[14] = mk(1,1,1,32'h200,     1,  0, 32'h20,       0, w(32'h1C),       32'h20,       1);
    tbl[15] = mk(0,0,0,32'h0,       0,  0, 32'h20,       0, w(32'h1C),       32'h20,       1);
    tbl[16] = mk(1,0,0,32'h0,       1,  1, 32'h24,       0, w(32'h20),       32'h24,       1);
    tbl[17] = mk(0,0,0,32'h0,       0,  0, 32'h24,       0, w(32'h20),       32'h24,       1);
    tbl[18] = mk(0,0,0,32'h0,       1,  1, 32'h28,       0, w(32'h24),       32'h28,       1);
    tbl[19] = mk(0,0,0,32'h0,       1,  1, 32'h2C,       0, w(32'h28),       32'h2C,       1);

    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].sf, tbl[i].sd, tbl[i].br, tbl[i].tgt, tbl[i].ack);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].fs,
              tbl[i].instr, tbl[i].pc4, tbl[i].valid);
      @(negedge clk);
    end

    // Reset while a request to 0x40 is pending: branch at 0x30 to 0x40.
    drive(0, 0, 1, 32'h40, 1'b1);
    #1;
    chk_all("br40", 1'b1, 32'h30, 1'b0, w(32'h2C), 32'h30, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 1'b0);
    #1;
    chk_all("pend40", 1'b1, 32'h40, 1'b1, slot(32'h30), 32'h34, DS);
    #2;
    rst = 1'b1;
    #1;
    chk_all("midrst", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 1'b1);
    #1;
    chk_all("restart_start", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk_all("restart_fetch0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    // PC wrap: branch at 0x4 to 0xFFFF_FFFC, whose PC+4 wraps to 0.
    drive(0, 0, 1, 32'hFFFF_FFFC, 1'b1);
    #1;
    chk_all("restart_d0", 1'b1, 32'h4, 1'b0, w(32'h0), 32'h4, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 1'b1);
    #1;
    chk_all("top", 1'b1, 32'hFFFF_FFFC, 1'b0, slot(32'h4), 32'h8, DS);
    @(negedge clk);
    #1;
    chk_all("wrap", 1'b1, 32'h0, 1'b0, w(32'hFFFF_FFFC), 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
